// File: rtl/jtag_tap_pkg.sv
// Shared types, constants and the TMS transition function for the JTAG TAP controller.
package jtag_tap_pkg;

    localparam int unsigned IR_LENGTH_DEF = 5;

    typedef enum logic [3:0] {
        TAP_TLR      = 4'd0,
        TAP_RTI      = 4'd1,
        TAP_SEL_DR   = 4'd2,
        TAP_CAP_DR   = 4'd3,
        TAP_SH_DR    = 4'd4,
        TAP_EX1_DR   = 4'd5,
        TAP_PAUSE_DR = 4'd6,
        TAP_EX2_DR   = 4'd7,
        TAP_UPD_DR   = 4'd8,
        TAP_SEL_IR   = 4'd9,
        TAP_CAP_IR   = 4'd10,
        TAP_SH_IR    = 4'd11,
        TAP_EX1_IR   = 4'd12,
        TAP_PAUSE_IR = 4'd13,
        TAP_EX2_IR   = 4'd14,
        TAP_UPD_IR   = 4'd15
    } tap_state_e;

    localparam logic [IR_LENGTH_DEF-1:0] BYPASS_IR  = '1;
    localparam logic [1:0]               IR_CAPTURE = 2'b01;

    // Standard 1149.1 TMS graph.
    function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        case (state)
            TAP_TLR:      nxt = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      nxt = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   nxt = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:    nxt = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR:   nxt = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: nxt = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   nxt = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR:   nxt = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   nxt = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:    nxt = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR:   nxt = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: nxt = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   nxt = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR:   nxt = tms ? TAP_SEL_DR : TAP_RTI;
            default:      nxt = TAP_TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// Two-flop synchronizers for the JTAG pins plus TCK edge detection on the system clock.
module jtag_pin_sync (
    input  logic clock,
    input  logic reset,
    input  logic tck_i,
    input  logic tms_i,
    input  logic tdi_i,
    input  logic trstn_i,
    output logic tms_o,
    output logic tdi_o,
    output logic trstn_o,
    output logic tck_rise_c,
    output logic tck_fall_c
);

    localparam int unsigned NPINS = 4;
    // Idle bus after reset: {trstn, tdi, tms, tck} = {1, 0, 1, 0}.
    localparam logic [NPINS-1:0] PIN_RESET = 4'b1010;

    logic [NPINS-1:0] meta_q;
    logic [NPINS-1:0] sync_q;
    logic             tck_prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q     <= PIN_RESET;
            sync_q     <= PIN_RESET;
            tck_prev_q <= 1'b0;
        end else begin
            meta_q     <= {trstn_i, tdi_i, tms_i, tck_i};
            sync_q     <= meta_q;
            tck_prev_q <= sync_q[0];
        end
    end

    assign tms_o      = sync_q[1];
    assign tdi_o      = sync_q[2];
    assign trstn_o    = sync_q[3];
    assign tck_rise_c = sync_q[0] & ~tck_prev_q;
    assign tck_fall_c = ~sync_q[0] & tck_prev_q;

endmodule

// File: rtl/jtag_tap_core.sv
// IEEE 1149.1 TAP controller: oversampled TCK, 16-state FSM, IR, IDCODE, BYPASS and a user DR
// with capture/update handshake toward the debug transport.
module jtag_tap_core
    import jtag_tap_pkg::*;
#(
    parameter int unsigned          IR_LENGTH     = 5,
    parameter logic [31:0]          IDCODE_VALUE  = 32'h0000_0001,
    parameter logic [IR_LENGTH-1:0] IDCODE_IR     = IR_LENGTH'(5'h01),
    parameter logic [IR_LENGTH-1:0] USER_IR       = IR_LENGTH'(5'h11),
    parameter int unsigned          USER_DR_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     jtag_TCK,
    input  logic                     jtag_TMS,
    input  logic                     jtag_TDI,
    input  logic                     jtag_TRSTn,
    output logic                     jtag_TDO_data,
    output logic                     jtag_TDO_driven,
    output logic [IR_LENGTH-1:0]     ir_value,
    input  logic [USER_DR_WIDTH-1:0] dr_capture_data,
    output logic                     dr_capture_strobe,
    output logic                     dr_update_valid,
    output logic [USER_DR_WIDTH-1:0] dr_update_data
);

    localparam int unsigned IDCODE_WIDTH = 32;

    logic tms_s;
    logic tdi_s;
    logic trstn_s;
    logic tck_rise_c;
    logic tck_fall_c;

    jtag_pin_sync u_pin_sync (
        .clock      (clock),
        .reset      (reset),
        .tck_i      (jtag_TCK),
        .tms_i      (jtag_TMS),
        .tdi_i      (jtag_TDI),
        .trstn_i    (jtag_TRSTn),
        .tms_o      (tms_s),
        .tdi_o      (tdi_s),
        .trstn_o    (trstn_s),
        .tck_rise_c (tck_rise_c),
        .tck_fall_c (tck_fall_c)
    );

    tap_state_e state_q;
    tap_state_e state_d;

    logic [IR_LENGTH-1:0]     ir_q;
    logic [IR_LENGTH-1:0]     ir_sr_q;
    logic [IDCODE_WIDTH-1:0]  idcode_sr_q;
    logic [USER_DR_WIDTH-1:0] user_sr_q;
    logic                     bypass_q;
    logic [USER_DR_WIDTH-1:0] upd_data_q;
    logic                     upd_valid_q;
    logic                     cap_strobe_q;
    logic                     tdo_q;
    logic                     tdo_drv_q;

    logic ir_cap_c;
    logic ir_shift_c;
    logic ir_upd_c;
    logic dr_cap_c;
    logic dr_shift_c;
    logic dr_upd_c;
    logic sel_idcode_c;
    logic sel_user_c;
    logic tdo_en_c;
    logic tdo_bit_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Synchronized TRSTn dominates any coincident TCK edge.
    always_comb begin
        state_d = state_q;
        if (!trstn_s) begin
            state_d = TAP_TLR;
        end else if (tck_rise_c) begin
            state_d = tap_next(state_q, tms_s);
        end
    end

    always_comb begin
        ir_cap_c   = 1'b0;
        ir_shift_c = 1'b0;
        ir_upd_c   = 1'b0;
        dr_cap_c   = 1'b0;
        dr_shift_c = 1'b0;
        dr_upd_c   = 1'b0;
        if (trstn_s && tck_rise_c) begin
            case (state_q)
                TAP_CAP_IR: ir_cap_c   = 1'b1;
                TAP_SH_IR:  ir_shift_c = 1'b1;
                TAP_UPD_IR: ir_upd_c   = 1'b1;
                TAP_CAP_DR: dr_cap_c   = 1'b1;
                TAP_SH_DR:  dr_shift_c = 1'b1;
                TAP_UPD_DR: dr_upd_c   = 1'b1;
                default:    ;
            endcase
        end
    end

    // Anything that is neither IDCODE nor USER falls through to BYPASS.
    assign sel_idcode_c = (ir_q == IDCODE_IR);
    assign sel_user_c   = (ir_q == USER_IR) && !sel_idcode_c;

    always_comb begin
        tdo_en_c  = 1'b0;
        tdo_bit_c = bypass_q;
        if (state_q == TAP_SH_IR) begin
            tdo_en_c  = 1'b1;
            tdo_bit_c = ir_sr_q[0];
        end else if (state_q == TAP_SH_DR) begin
            tdo_en_c = 1'b1;
            if (sel_idcode_c) begin
                tdo_bit_c = idcode_sr_q[0];
            end else if (sel_user_c) begin
                tdo_bit_c = user_sr_q[0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q         <= IDCODE_IR;
            ir_sr_q      <= '0;
            idcode_sr_q  <= '0;
            user_sr_q    <= '0;
            bypass_q     <= 1'b0;
            upd_data_q   <= '0;
            upd_valid_q  <= 1'b0;
            cap_strobe_q <= 1'b0;
            tdo_q        <= 1'b0;
            tdo_drv_q    <= 1'b0;
        end else begin
            upd_valid_q  <= dr_upd_c && sel_user_c;
            cap_strobe_q <= dr_cap_c && sel_user_c;

            if (ir_cap_c) begin
                ir_sr_q <= IR_LENGTH'(IR_CAPTURE);
            end else if (ir_shift_c) begin
                ir_sr_q <= {tdi_s, ir_sr_q[IR_LENGTH-1:1]};
            end

            if (state_d == TAP_TLR) begin
                ir_q <= IDCODE_IR;
            end else if (ir_upd_c) begin
                ir_q <= ir_sr_q;
            end

            if (dr_cap_c) begin
                if (sel_idcode_c) begin
                    idcode_sr_q <= IDCODE_VALUE;
                end else if (sel_user_c) begin
                    user_sr_q <= dr_capture_data;
                end else begin
                    bypass_q <= 1'b0;
                end
            end else if (dr_shift_c) begin
                if (sel_idcode_c) begin
                    idcode_sr_q <= {tdi_s, idcode_sr_q[IDCODE_WIDTH-1:1]};
                end else if (sel_user_c) begin
                    user_sr_q <= {tdi_s, user_sr_q[USER_DR_WIDTH-1:1]};
                end else begin
                    bypass_q <= tdi_s;
                end
            end

            if (dr_upd_c && sel_user_c) begin
                upd_data_q <= user_sr_q;
            end

            // TDO changes on the falling TCK edge so the host samples it stable on the next rise.
            if (tck_fall_c) begin
                tdo_drv_q <= tdo_en_c;
                if (tdo_en_c) begin
                    tdo_q <= tdo_bit_c;
                end
            end
        end
    end

    assign jtag_TDO_data     = tdo_q;
    assign jtag_TDO_driven   = tdo_drv_q;
    assign ir_value          = ir_q;
    assign dr_capture_strobe = cap_strobe_q;
    assign dr_update_valid   = upd_valid_q;
    assign dr_update_data    = upd_data_q;

endmodule
